mem_bridge_sched: RTL and testbench
===================================

# mem_bridge_sched

Two-requester scheduler for the MainBus↔MemData bridge and the memory strobes. It arbitrates between the CPU pipeline memory stage and the DMA engine, then sequences each granted access. Each read or write drives the bridge enables, memory output/write enables and address-source select with a guaranteed dead cycle on every bridge direction change. The two bridge directions are never enabled together.

## Interface
- `READ_WAIT`, 0: extra RD cycles beyond the first (0–3).
- `WE_PULSE`, 1: cycles `mem_we_n` is held low (1–4).
- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cpu_req` in 1: CPU access request, level, held until ack.
- `cpu_we` in 1: 1 = write, 0 = read; stable while `cpu_req` high.
- `cpu_ack` out 1: one-cycle pulse in the final cycle of the CPU access.
- `dma_req`, `dma_we`, `dma_ack`: same as the CPU signals, for DMA.
- `addr_sel` out 1: address-bus source, 0 = CPU, 1 = DMA.
- `a_membridge_n` out 1: low drives MemData onto MainBus (read).
- `d_membridge_n` out 1: low drives MainBus onto MemData (write).
- `mem_oe_n` out 1: memory output enable, active low.
- `mem_we_n` out 1: memory write enable, active low.
- `busy` out 1: high in every non-IDLE state.

## Operation
- States: IDLE, TURN, RD, WR_SU, WR_P, WR_H.
- Outputs are Moore-decoded from registered state and counter only; no request-to-output combinational path.
- IDLE:
  - On any request, the arbiter picks a winner, latches `addr_sel` and the `we` bit, and compares direction with `last_dir`.
  - Direction differs → TURN. Direction matches → RD (read) or WR_SU (write).
- TURN: one cycle with all enables inactive, then RD or WR_SU. `last_dir` is updated on leaving TURN.
- RD: `a_membridge_n` = 0 and `mem_oe_n` = 0 for 1+`READ_WAIT` cycles; ack asserted in the last cycle; then IDLE.
- Write sequence:
  - WR_SU: `d_membridge_n` = 0 for 1 cycle.
  - WR_P: `d_membridge_n` = 0 and `mem_we_n` = 0 for `WE_PULSE` cycles.
  - WR_H: `d_membridge_n` = 0 for 1 cycle, ack asserted, then IDLE.
- Invariants:
  - `a_membridge_n` and `d_membridge_n` are never both 0.
  - `mem_we_n` = 0 only while `d_membridge_n` = 0.
  - `mem_oe_n` = 0 only while `a_membridge_n` = 0.
- Handshake:
  - The requester deasserts `req` in the cycle after it samples ack.
  - `req` high in the cycle after ack is a new request.
  - Changing `we` mid-request is illegal; the latched value is used.
- The state always returns to IDLE after ack, so there is at least one IDLE cycle between accesses.
- Reset values: state IDLE, counter 0, `last_dir` = read, last-grant = DMA. All `_n` outputs 1; `addr_sel`, acks and `busy` 0.
- Reset mid-access: outputs go inactive asynchronously and immediately. The access is abandoned with no ack.

## Timing
- Request high in cycle 0 (IDLE), same direction: access states start in cycle 1.
- Read ack: cycle 1+`READ_WAIT`.
- Write ack: cycle 2+`WE_PULSE`.
- A direction change adds exactly 1 cycle.
- Simultaneous requests in IDLE are resolved the same cycle. The loser's `req` stays high and is granted from the next IDLE.
- A request arriving while `busy` waits; no queue depth beyond the held level.
- The counter is 2 bits and saturates at parameter−1; no wrap.

## Configuration
- `MEM_BRIDGE_RR_EN` defined: round-robin. On simultaneous requests, the requester not granted last wins; last-grant updates at each grant.
- Undefined: fixed priority, CPU always wins. The last-grant register is not built.

## Structure
- Package `mem_bridge_pkg` holds:
  - state encoding constants;
  - `DIR_RD`/`DIR_WR`;
  - requester IDs `REQ_CPU` = 0, `REQ_DMA` = 1.
- Sub-module `mem_bridge_arb`: 2-way arbiter with inputs `req[1:0]`, `grant_en`, outputs `grant_id`, `grant_valid`. Holds the RR pointer under `MEM_BRIDGE_RR_EN`.

## Test plan
- CPU read, `READ_WAIT` = 0, `last_dir` = read: `cpu_req` in cycle 0 → cycle 1 `a_membridge_n` = 0, `mem_oe_n` = 0, `cpu_ack` = 1; cycle 2 IDLE, all outputs inactive.
- CPU write after a read, `WE_PULSE` = 2: cycle 1 TURN (all high), cycle 2 WR_SU, cycles 3–4 `mem_we_n` = 0, cycle 5 WR_H with `cpu_ack`; `d_membridge_n` low cycles 2–5 only.
- `cpu_req` and `dma_req` together twice: fixed priority → CPU, CPU. Round-robin → CPU then DMA. `addr_sel` is 1 throughout the DMA access.
- Back-to-back DMA writes: no TURN between them; exactly 1 IDLE cycle between the first `dma_ack` and the next WR_SU.
- `rst_n` low during WR_P: `mem_we_n`/`d_membridge_n` rise with no clock edge; no ack; state is IDLE after release.
- Random stress of 10k cycles: assertions for bridge-enable exclusivity, strobe containment and exactly one ack per request.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the MainBus<->MemData bridge scheduler.
// Imported by mem_bridge_arb and mem_bridge_sched.
package mem_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TURN  = 3'd1,
        RD    = 3'd2,
        WR_SU = 3'd3,
        WR_P  = 3'd4,
        WR_H  = 3'd5
    } state_t;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef struct packed {
        logic a_membridge_n;
        logic d_membridge_n;
        logic mem_oe_n;
        logic mem_we_n;
        logic busy;
    } strobe_t;

    // Memory strobes only ever assert inside the matching bridge direction.
    function automatic strobe_t decode_strobes(input state_t st);
        strobe_t s;
        s.a_membridge_n = 1'b1;
        s.d_membridge_n = 1'b1;
        s.mem_oe_n      = 1'b1;
        s.mem_we_n      = 1'b1;
        s.busy          = 1'b1;
        case (st)
            IDLE: s.busy = 1'b0;
            TURN: ;
            RD: begin
                s.a_membridge_n = 1'b0;
                s.mem_oe_n      = 1'b0;
            end
            WR_SU, WR_H: s.d_membridge_n = 1'b0;
            WR_P: begin
                s.d_membridge_n = 1'b0;
                s.mem_we_n      = 1'b0;
            end
            default: s.busy = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_bridge_arb.sv
// Two-way arbiter between CPU and DMA requests. Fixed CPU priority by default;
// define MEM_BRIDGE_RR_EN for round-robin with a last-grant pointer.
module mem_bridge_arb
    import mem_bridge_pkg::*;
(
`ifdef MEM_BRIDGE_RR_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       grant_id,
    output logic       grant_valid
);

    assign grant_valid = grant_en && (req != 2'b00);

`ifdef MEM_BRIDGE_RR_EN
    logic last_grant;

    // On a tie the requester that was not served last wins.
    always_comb begin
        if (req[REQ_CPU] && req[REQ_DMA]) begin
            grant_id = (last_grant == REQ_CPU) ? REQ_DMA : REQ_CPU;
        end else begin
            grant_id = req[REQ_CPU] ? REQ_CPU : REQ_DMA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= REQ_DMA;
        end else if (grant_valid) begin
            last_grant <= grant_id;
        end
    end
`else
    assign grant_id = req[REQ_CPU] ? REQ_CPU : REQ_DMA;
`endif

endmodule

// File: rtl/mem_bridge_sched.sv
// Scheduler for the MainBus<->MemData bridge and memory strobes, with a dead
// TURN cycle on every bridge direction change. MEM_BRIDGE_RR_EN selects round-robin arbitration.
module mem_bridge_sched
    import mem_bridge_pkg::*;
#(
    parameter int READ_WAIT = 0,
    parameter int WE_PULSE  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cpu_req,
    input  logic cpu_we,
    output logic cpu_ack,
    input  logic dma_req,
    input  logic dma_we,
    output logic dma_ack,
    output logic addr_sel,
    output logic a_membridge_n,
    output logic d_membridge_n,
    output logic mem_oe_n,
    output logic mem_we_n,
    output logic busy
);

    localparam logic [1:0] RD_LAST = 2'(READ_WAIT);
    localparam logic [1:0] WP_LAST = 2'(WE_PULSE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] cnt;
    logic [1:0] cnt_nxt;
    logic       cur_we;
    logic       we_nxt;
    logic       last_dir;
    logic       dir_nxt;
    logic       sel_nxt;
    logic       ack_nxt;
    logic       grant_id;
    logic       grant_valid;
    logic       grant_we;
    strobe_t    strobes_nxt;

    mem_bridge_arb u_arb (
`ifdef MEM_BRIDGE_RR_EN
        .clk         (clk),
        .rst_n       (rst_n),
`endif
        .req         ({dma_req, cpu_req}),
        .grant_en    (state == IDLE),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    assign grant_we = (grant_id == REQ_DMA) ? dma_we : cpu_we;

    // Next-state logic; the counter never passes its last value, so it cannot wrap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = addr_sel;
        we_nxt    = cur_we;
        dir_nxt   = last_dir;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    sel_nxt = grant_id;
                    we_nxt  = grant_we;
                    cnt_nxt = '0;
                    if (grant_we != last_dir) begin
                        state_nxt = TURN;
                    end else if (grant_we == DIR_WR) begin
                        state_nxt = WR_SU;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            TURN: begin
                dir_nxt   = cur_we;
                state_nxt = (cur_we == DIR_WR) ? WR_SU : RD;
            end
            RD: begin
                if (cnt == RD_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            WR_SU: begin
                state_nxt = WR_P;
                cnt_nxt   = '0;
            end
            WR_P: begin
                if (cnt == WP_LAST) begin
                    state_nxt = WR_H;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            WR_H: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign strobes_nxt = decode_strobes(state_nxt);
    assign ack_nxt     = ((state_nxt == RD) && (cnt_nxt == RD_LAST)) || (state_nxt == WR_H);

    // Outputs are registered from the next state so they are glitch-free and
    // drop to their inactive levels the instant rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            cur_we        <= DIR_RD;
            last_dir      <= DIR_RD;
            addr_sel      <= REQ_CPU;
            a_membridge_n <= 1'b1;
            d_membridge_n <= 1'b1;
            mem_oe_n      <= 1'b1;
            mem_we_n      <= 1'b1;
            busy          <= 1'b0;
            cpu_ack       <= 1'b0;
            dma_ack       <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            cur_we        <= we_nxt;
            last_dir      <= dir_nxt;
            addr_sel      <= sel_nxt;
            a_membridge_n <= strobes_nxt.a_membridge_n;
            d_membridge_n <= strobes_nxt.d_membridge_n;
            mem_oe_n      <= strobes_nxt.mem_oe_n;
            mem_we_n      <= strobes_nxt.mem_we_n;
            busy          <= strobes_nxt.busy;
            cpu_ack       <= ack_nxt && (sel_nxt == REQ_CPU);
            dma_ack       <= ack_nxt && (sel_nxt == REQ_DMA);
        end
    end

endmodule

// File: tb/tb_mem_bridge_sched.sv
// Testbench for mem_bridge_sched: directed vector table, async reset case and
// randomized stress against a transaction-level reference model.
module tb_mem_bridge_sched;

    localparam int RW = 0;
    localparam int WP = 2;
`ifdef MEM_BRIDGE_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic cpu_req, cpu_we, cpu_ack;
    logic dma_req, dma_we, dma_ack;
    logic addr_sel, a_membridge_n, d_membridge_n, mem_oe_n, mem_we_n, busy;

    typedef struct packed {
        logic a_n;
        logic d_n;
        logic oe_n;
        logic we_n;
        logic sel;
        logic cpu_ack;
        logic dma_ack;
        logic busy;
    } out_t;

    typedef struct packed {
        logic cpu_req;
        logic cpu_we;
        logic dma_req;
        logic dma_we;
        out_t exp;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    vec_t vecs[$];
    out_t q[$];
    out_t cur, ended;
    logic m_dir, m_last, m_sel;
    int   m_cpu_acks, m_dma_acks, d_cpu_acks, d_dma_acks;

    mem_bridge_sched #(.READ_WAIT(RW), .WE_PULSE(WP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_ack       (cpu_ack),
        .dma_req       (dma_req),
        .dma_we        (dma_we),
        .dma_ack       (dma_ack),
        .addr_sel      (addr_sel),
        .a_membridge_n (a_membridge_n),
        .d_membridge_n (d_membridge_n),
        .mem_oe_n      (mem_oe_n),
        .mem_we_n      (mem_we_n),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic out_t mkv(input logic a, input logic d, input logic oe, input logic we,
                                 input logic sel, input logic ack, input logic bsy);
        out_t v;
        v.a_n     = a;
        v.d_n     = d;
        v.oe_n    = oe;
        v.we_n    = we;
        v.sel     = sel;
        v.cpu_ack = ack & ~sel;
        v.dma_ack = ack & sel;
        v.busy    = bsy;
        return v;
    endfunction

    function automatic out_t v_idle(input logic s);           return mkv(1, 1, 1, 1, s, 0, 0);   endfunction
    function automatic out_t v_turn(input logic s);           return mkv(1, 1, 1, 1, s, 0, 1);   endfunction
    function automatic out_t v_rd(input logic s, input logic k); return mkv(0, 1, 0, 1, s, k, 1); endfunction
    function automatic out_t v_su(input logic s);             return mkv(1, 0, 1, 1, s, 0, 1);   endfunction
    function automatic out_t v_p(input logic s);              return mkv(1, 0, 1, 0, s, 0, 1);   endfunction
    function automatic out_t v_h(input logic s);              return mkv(1, 0, 1, 1, s, 1, 1);   endfunction

    function automatic out_t sample();
        out_t o;
        o = {a_membridge_n, d_membridge_n, mem_oe_n, mem_we_n, addr_sel, cpu_ack, dma_ack, busy};
        return o;
    endfunction

    task automatic addRow(input logic cr, input logic cw, input logic dr, input logic dw, input out_t e);
        vec_t v;
        v = {cr, cw, dr, dw, e};
        vecs.push_back(v);
    endtask

    task automatic addWrite(input logic cr, input logic dr, input logic s);
        addRow(cr, 1, dr, 1, v_su(s));
        for (int k = 0; k < WP; k++) addRow(cr, 1, dr, 1, v_p(s));
        addRow(cr, 1, dr, 1, v_h(s));
    endtask

    task automatic applyStimulus(input vec_t v);
        cpu_req = v.cpu_req;
        cpu_we  = v.cpu_we;
        dma_req = v.dma_req;
        dma_we  = v.dma_we;
    endtask

    task automatic checkOutput(input string name, input out_t exp);
        out_t act;
        act = sample();
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: a/d/oe/we/sel/cack/dack/busy got %b required %b", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    // Reference arbitration and access shape, built as a list of per-cycle outputs.
    task automatic modelGrant();
        logic id, we;
        if (cpu_req && dma_req) id = RR ? ~m_last : 1'b0;
        else                    id = dma_req;
        we     = id ? dma_we : cpu_we;
        m_last = id;
        m_sel  = id;
        if (we != m_dir) q.push_back(v_turn(id));
        m_dir = we;
        if (!we) begin
            for (int k = 0; k <= RW; k++) q.push_back(v_rd(id, (k == RW)));
        end else begin
            q.push_back(v_su(id));
            for (int k = 0; k < WP; k++) q.push_back(v_p(id));
            q.push_back(v_h(id));
        end
    endtask

    task automatic randRequester(input logic acked, inout logic req, inout logic we);
        if (acked) begin
            if ($urandom_range(0, 3) == 0) begin
                req = 1'b1;
                we  = 1'($urandom_range(0, 1));
            end else begin
                req = 1'b0;
            end
        end else if (!req && $urandom_range(0, 2) == 0) begin
            req = 1'b1;
            we  = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        logic w2, l2;
        cpu_req = 0; cpu_we = 0; dma_req = 0; dma_we = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 checkOutput("reset_values", v_idle(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        w2 = RR ? 1'b1 : 1'b0;
        l2 = ~w2;
        // CPU read, no direction change
        addRow(1, 0, 0, 0, v_idle(0));
        addRow(1, 0, 0, 0, v_rd(0, 1));
        addRow(0, 0, 0, 0, v_idle(0));
        // CPU write after read: one dead TURN cycle
        addRow(1, 1, 0, 0, v_idle(0));
        addRow(1, 1, 0, 0, v_turn(0));
        addWrite(1, 0, 0);
        addRow(0, 0, 0, 0, v_idle(0));
        // Simultaneous writes twice, then the held loser
        addRow(1, 1, 1, 1, v_idle(0));
        addWrite(1, 1, 0);
        addRow(1, 1, 1, 1, v_idle(0));
        addWrite(1, 1, w2);
        addRow(w2, 1, ~w2, 1, v_idle(w2));
        addWrite(w2, ~w2, l2);
        addRow(0, 0, 0, 0, v_idle(l2));
        // Back-to-back DMA writes, then a DMA read needing TURN
        addRow(0, 0, 1, 1, v_idle(l2));
        addWrite(0, 1, 1);
        addRow(0, 0, 1, 1, v_idle(1));
        addWrite(0, 1, 1);
        addRow(0, 0, 0, 0, v_idle(1));
        addRow(0, 0, 1, 0, v_idle(1));
        addRow(0, 0, 1, 0, v_turn(1));
        addRow(0, 0, 1, 0, v_rd(1, 1));
        addRow(0, 0, 0, 0, v_idle(1));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
            @(posedge clk); #1;
        end

        // Reset asserted in the middle of a write pulse
        cpu_req = 1; cpu_we = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("wr_p_before_reset", v_p(0));
        #2 rst_n = 1'b0;
        #1;
        checkBit("rst_async_we_n", mem_we_n, 1'b1);
        checkBit("rst_async_d_n", d_membridge_n, 1'b1);
        checkBit("rst_async_busy", busy, 1'b0);
        cpu_req = 0; cpu_we = 0;
        repeat (2) begin
            @(negedge clk);
            checkBit("rst_hold_no_ack", cpu_ack, 1'b0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_reset_idle", v_idle(0));
        cpu_req = 1; cpu_we = 0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("post_reset_read", v_rd(0, 1));
        @(posedge clk); #1;
        cpu_req = 0;
        @(negedge clk);
        checkOutput("post_reset_read_done", v_idle(0));

        // Randomized stress against the reference model
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        m_dir = 1'b0; m_last = 1'b1; m_sel = 1'b0;
        cur = v_idle(0);
        m_cpu_acks = 0; m_dma_acks = 0; d_cpu_acks = 0; d_dma_acks = 0;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            ended = cur;
            if (!ended.busy && (cpu_req || dma_req)) modelGrant();
            if (q.size() > 0) cur = q.pop_front();
            else              cur = v_idle(m_sel);
            if (cur.cpu_ack) m_cpu_acks++;
            if (cur.dma_ack) m_dma_acks++;
            #1;
            randRequester(ended.cpu_ack, cpu_req, cpu_we);
            randRequester(ended.dma_ack, dma_req, dma_we);
            @(negedge clk);
            checkOutput($sformatf("stress_c%0d", c), cur);
            checkBit("excl_bridge", !(a_membridge_n == 1'b0 && d_membridge_n == 1'b0), 1'b1);
            checkBit("we_in_d", !(mem_we_n == 1'b0 && d_membridge_n == 1'b1), 1'b1);
            checkBit("oe_in_a", !(mem_oe_n == 1'b0 && a_membridge_n == 1'b1), 1'b1);
            checkBit("ack_with_req", !((cpu_ack && !cpu_req) || (dma_ack && !dma_req)), 1'b1);
            if (cpu_ack) d_cpu_acks++;
            if (dma_ack) d_dma_acks++;
        end
        n_cmp++;
        if (d_cpu_acks != m_cpu_acks) begin
            n_fail++;
            $display("[TB] FAIL cpu_ack_count: got %0d required %0d", d_cpu_acks, m_cpu_acks);
        end
        n_cmp++;
        if (d_dma_acks != m_dma_acks) begin
            n_fail++;
            $display("[TB] FAIL dma_ack_count: got %0d required %0d", d_dma_acks, m_dma_acks);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
